// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and its mult/div sequencer:
// aluOp classes, funct codes, ALU control codes and the sequencer FSM states.
package alu_ctrl_pkg;

  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;
  localparam logic [2:0] AOP_AND   = 3'b011;
  localparam logic [2:0] AOP_OR    = 3'b100;
  localparam logic [2:0] AOP_SLT   = 3'b101;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [3:0] CTR_AND     = 4'b0000;
  localparam logic [3:0] CTR_OR      = 4'b0001;
  localparam logic [3:0] CTR_ADD     = 4'b0010;
  localparam logic [3:0] CTR_XOR     = 4'b0011;
  localparam logic [3:0] CTR_SUB     = 4'b0110;
  localparam logic [3:0] CTR_SLT     = 4'b0111;
  localparam logic [3:0] CTR_NOR     = 4'b1100;
  localparam logic [3:0] CTR_MFHI    = 4'b1101;
  localparam logic [3:0] CTR_MFLO    = 4'b1110;
  localparam logic [3:0] CTR_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  // mult, multu, div, divu share the 0110xx prefix
  function automatic logic is_md_funct(input logic [5:0] fn);
    return (fn[5:2] == 4'b0110);
  endfunction

  function automatic logic [3:0] decode_funct(input logic [5:0] fn);
    logic [3:0] c;
    case (fn)
      FN_ADD:  c = CTR_ADD;
      FN_SUB:  c = CTR_SUB;
      FN_AND:  c = CTR_AND;
      FN_OR:   c = CTR_OR;
      FN_XOR:  c = CTR_XOR;
      FN_NOR:  c = CTR_NOR;
      FN_SLT:  c = CTR_SLT;
      FN_MFHI: c = CTR_MFHI;
      FN_MFLO: c = CTR_MFLO;
      default: c = CTR_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] decode_op(input logic [2:0] op, input logic [5:0] fn);
    logic [3:0] c;
    case (op)
      AOP_ADD:   c = CTR_ADD;
      AOP_SUB:   c = CTR_SUB;
      AOP_AND:   c = CTR_AND;
      AOP_OR:    c = CTR_OR;
      AOP_SLT:   c = CTR_SLT;
      AOP_RTYPE: c = decode_funct(fn);
      default:   c = CTR_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_md_iter.sv
// Magnitude-only iterative multiply (shift-add) / divide (restoring), one bit
// per cycle for DATA_W cycles after start; done flags the final iteration.
module md_iter #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              isDiv,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] hiMag,
  output logic [DATA_W-1:0] loMag
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_div;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W:0]   w_top;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_hi_nxt;
  logic [DATA_W-1:0] w_lo_nxt;

  // One iteration: {hi,lo} is the product accumulator or the remainder/quotient pair
  always_comb begin
    w_top    = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_m}) : {1'b0, r_hi};
    w_shift  = {r_hi, r_lo[DATA_W-1]};
    w_diff   = w_shift[DATA_W-1:0] - r_m;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_div) begin
      if (w_shift >= {1'b0, r_m}) begin
        w_hi_nxt = w_diff;
        w_lo_nxt = {r_lo[DATA_W-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[DATA_W-1:0];
        w_lo_nxt = {r_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_top[DATA_W:1];
      w_lo_nxt = {w_top[0], r_lo[DATA_W-1:1]};
    end
  end

  // Operand load on start, then DATA_W iterations
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CNT_W{1'b0}};
      r_div <= 1'b0;
      r_m   <= {DATA_W{1'b0}};
      r_hi  <= {DATA_W{1'b0}};
      r_lo  <= {DATA_W{1'b0}};
    end else if (start) begin
      r_cnt <= CNT_W'(DATA_W);
      r_div <= isDiv;
      r_m   <= isDiv ? b : a;
      r_hi  <= {DATA_W{1'b0}};
      r_lo  <= isDiv ? a : b;
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

  assign done  = (r_cnt == CNT_W'(1));
  assign hiMag = r_hi;
  assign loMag = r_lo;

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with valid/ready handshake and a registered control code,
// plus the mult/div sequencer (IDLE/RUN/FIX) that owns the HI/LO registers.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int CTR_W  = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic [OP_W-1:0]   aluOp,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic              outValid,
  output logic [CTR_W-1:0]  aluCtrOut,
  output logic              mdBusy,
  output logic              mdDone,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_e           r_state;
  md_state_e           w_state_nxt;
  logic                r_out_valid;
  logic [CTR_W-1:0]    r_ctr;
  logic                r_md_done;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_signed;
  logic                r_div;
  logic                r_dz;
  logic                r_sa;
  logic                r_sb;
  logic [DATA_W-1:0]   r_opa;

  logic                w_accept;
  logic                w_op_ok;
  logic                w_is_md;
  logic [3:0]          w_code;
  logic                w_md_start;
  logic                w_signed_in;
  logic                w_div_in;
  logic                w_dz_in;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic                w_done;
  logic [DATA_W-1:0]   w_hi_mag;
  logic [DATA_W-1:0]   w_lo_mag;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_neg_pq;
  logic [DATA_W-1:0]   w_hi_nxt;
  logic [DATA_W-1:0]   w_lo_nxt;

  assign mdBusy    = (r_state != S_IDLE);
  assign inReady   = !mdBusy;
  assign outValid  = r_out_valid;
  assign aluCtrOut = r_ctr;
  assign mdDone    = r_md_done;
  assign hi        = r_hi;
  assign lo        = r_lo;

  // Widened aluOp: anything beyond the 3-bit encodings is illegal
  assign w_accept    = inValid && inReady;
  assign w_op_ok     = ((aluOp >> 3) == {OP_W{1'b0}});
  assign w_is_md     = w_op_ok && (aluOp[2:0] == AOP_RTYPE) && is_md_funct(funct);
  assign w_code      = w_op_ok ? decode_op(aluOp[2:0], funct) : CTR_ILLEGAL;
  assign w_md_start  = w_accept && w_is_md;
  assign w_signed_in = !funct[0];
  assign w_div_in    = funct[1];
  assign w_dz_in     = w_div_in && (opB == {DATA_W{1'b0}});
  assign w_mag_a     = (w_signed_in && opA[DATA_W-1]) ? -opA : opA;
  assign w_mag_b     = (w_signed_in && opB[DATA_W-1]) ? -opB : opB;

  md_iter #(.DATA_W(DATA_W)) u_md_iter (
    .Clk   (Clk),
    .reset (reset),
    .start (w_md_start && !w_dz_in),
    .isDiv (w_div_in),
    .a     (w_mag_a),
    .b     (w_mag_b),
    .done  (w_done),
    .hiMag (w_hi_mag),
    .loMag (w_lo_mag)
  );

  // Sequencer state register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Divide by zero has no iterations to run and goes straight to the sign/fix cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_md_start) w_state_nxt = w_dz_in ? S_FIX : S_RUN;
        else            w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_done) w_state_nxt = S_FIX;
        else        w_state_nxt = S_RUN;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sign fix: product/quotient negate on sign mismatch, remainder follows dividend
  always_comb begin
    w_prod   = {w_hi_mag, w_lo_mag};
    w_neg_pq = r_signed && (r_sa ^ r_sb);
    if (r_dz) begin
      w_hi_nxt = r_opa;
      w_lo_nxt = {DATA_W{1'b1}};
    end else if (r_div) begin
      w_hi_nxt = (r_signed && r_sa) ? -w_hi_mag : w_hi_mag;
      w_lo_nxt = w_neg_pq ? -w_lo_mag : w_lo_mag;
    end else begin
      {w_hi_nxt, w_lo_nxt} = w_neg_pq ? -w_prod : w_prod;
    end
  end

  // Operation attributes captured at accept
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_signed <= 1'b0;
      r_div    <= 1'b0;
      r_dz     <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_opa    <= {DATA_W{1'b0}};
    end else if (w_md_start) begin
      r_signed <= w_signed_in;
      r_div    <= w_div_in;
      r_dz     <= w_dz_in;
      r_sa     <= opA[DATA_W-1];
      r_sb     <= opB[DATA_W-1];
      r_opa    <= opA;
    end
  end

  // Control-code result and HI/LO update
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_ctr       <= {CTR_W{1'b0}};
      r_md_done   <= 1'b0;
      r_hi        <= {DATA_W{1'b0}};
      r_lo        <= {DATA_W{1'b0}};
    end else begin
      r_out_valid <= w_accept && !w_is_md;
      if (w_accept && !w_is_md) r_ctr <= CTR_W'(w_code);
      r_md_done <= (r_state == S_FIX);
      if (r_state == S_FIX) begin
        r_hi <= w_hi_nxt;
        r_lo <= w_lo_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus pushes hand-computed expectations,
// a negedge monitor pops one per outValid/mdDone and checks value, cycle and busy length.
module tb_alu_ctrl_seq;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  aluOp = 3'b000;
  logic [5:0]  funct = 6'b000000;
  logic [31:0] opA = 32'h0;
  logic [31:0] opB = 32'h0;
  logic        outValid;
  logic [3:0]  aluCtrOut;
  logic        mdBusy;
  logic        mdDone;
  logic [31:0] hi;
  logic [31:0] lo;

  alu_ctrl_seq #(.DATA_W(32), .OP_W(3), .CTR_W(4)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .inValid   (inValid),
    .inReady   (inReady),
    .aluOp     (aluOp),
    .funct     (funct),
    .opA       (opA),
    .opB       (opB),
    .outValid  (outValid),
    .aluCtrOut (aluCtrOut),
    .mdBusy    (mdBusy),
    .mdDone    (mdDone),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    bit          is_md;
    logic [3:0]  ctr;
    bit          chk_hl;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   busy_run = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t ctl(input logic [3:0] c);
    exp_t e;
    e.tag = ""; e.is_md = 1'b0; e.ctr = c; e.chk_hl = 1'b0;
    e.hi = 32'h0; e.lo = 32'h0; e.busy = 0; e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t ctl_hl(input logic [3:0] c, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e = ctl(c);
    e.chk_hl = 1'b1; e.hi = h; e.lo = l;
    return e;
  endfunction

  function automatic exp_t mdx(input logic [31:0] h, input logic [31:0] l, input int busy);
    exp_t e;
    e = ctl(4'b0000);
    e.is_md = 1'b1; e.hi = h; e.lo = l; e.busy = busy;
    return e;
  endfunction

  task automatic check_out(input bit md);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL unexpected_%s: output pulse with no pending request (ctr=%h hi=%h lo=%h)",
               md ? "mdDone" : "outValid", aluCtrOut, hi, lo);
      return;
    end
    e = q.pop_front();
    chk({e.tag, "_kind"}, {63'h0, md}, {63'h0, e.is_md});
    chk({e.tag, "_cycle"}, cyc, e.cyc);
    if (md) begin
      chk({e.tag, "_hi"}, hi, e.hi);
      chk({e.tag, "_lo"}, lo, e.lo);
      chk({e.tag, "_busy_cycles"}, busy_run, e.busy);
      busy_run = 0;
    end else begin
      chk({e.tag, "_aluCtrOut"}, aluCtrOut, e.ctr);
      if (e.chk_hl) begin
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
      end
    end
  endtask

  initial forever begin
    @(negedge Clk);
    if (!reset) begin
      busy_run = 0;
    end else begin
      if (mdBusy) busy_run++;
      if (mdDone) check_out(1'b1);
      if (outValid) check_out(1'b0);
    end
  end

  // Present a request, wait for inReady, push its expectation, return the accept cycle
  task automatic send(input string tag, input logic [2:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input exp_t e, output int acc);
    int n;
    n = 0;
    inValid = 1'b1; aluOp = op; funct = fn; opA = a; opB = b;
    while (!inReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!inReady) begin
      vectors++;
      errors++;
      $display("FAIL %s_accept_timeout: inReady=%b, expected 1", tag, inReady);
      acc = -1;
      return;
    end
    e.tag = tag;
    e.cyc = cyc + (e.is_md ? e.busy + 1 : 1);
    q.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    acc = cyc;
  endtask

  initial begin
    int acc;
    int acc_m;
    int n;

    repeat (3) @(negedge Clk);
    chk("rst_outValid", {63'h0, outValid}, 64'h0);
    chk("rst_aluCtrOut", {60'h0, aluCtrOut}, 64'h0);
    chk("rst_mdBusy", {63'h0, mdBusy}, 64'h0);
    chk("rst_mdDone", {63'h0, mdDone}, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    reset = 1'b1;
    @(negedge Clk);
    chk("rst_inReady", {63'h0, inReady}, 64'h1);

    send("add",     3'b000, 6'b000000, 32'h0, 32'h0, ctl(4'b0010), acc);
    send("sub",     3'b001, 6'b000000, 32'h0, 32'h0, ctl(4'b0110), acc);
    send("r_add",   3'b010, 6'b100000, 32'h0, 32'h0, ctl(4'b0010), acc);
    send("r_sub",   3'b010, 6'b100010, 32'h0, 32'h0, ctl(4'b0110), acc);
    send("r_and",   3'b010, 6'b100100, 32'h0, 32'h0, ctl(4'b0000), acc);
    send("r_or",    3'b010, 6'b100101, 32'h0, 32'h0, ctl(4'b0001), acc);
    send("r_slt",   3'b010, 6'b101010, 32'h0, 32'h0, ctl(4'b0111), acc);
    send("r_xor",   3'b010, 6'b100110, 32'h0, 32'h0, ctl(4'b0011), acc);
    send("r_nor",   3'b010, 6'b100111, 32'h0, 32'h0, ctl(4'b1100), acc);
    send("i_and",   3'b011, 6'b000000, 32'h0, 32'h0, ctl(4'b0000), acc);
    send("i_or",    3'b100, 6'b000000, 32'h0, 32'h0, ctl(4'b0001), acc);
    send("i_slt",   3'b101, 6'b000000, 32'h0, 32'h0, ctl(4'b0111), acc);
    send("ill_op6", 3'b110, 6'b100000, 32'h0, 32'h0, ctl(4'b1111), acc);
    send("r_add2",  3'b010, 6'b100000, 32'h0, 32'h0, ctl(4'b0010), acc);
    send("ill_op7", 3'b111, 6'b000000, 32'h0, 32'h0, ctl(4'b1111), acc);
    send("ill_fn",  3'b010, 6'b001000, 32'h0, 32'h0, ctl(4'b1111), acc);
    inValid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("hold_aluCtrOut", {60'h0, aluCtrOut}, 64'hF);
    chk("hold_outValid", {63'h0, outValid}, 64'h0);

    send("mult", 3'b010, 6'b011000, 32'hFFFFFFFD, 32'h00000007,
         mdx(32'hFFFFFFFF, 32'hFFFFFFEB, 33), acc_m);
    send("stall_add", 3'b000, 6'b000000, 32'h12345678, 32'h0, ctl(4'b0010), acc);
    chk("stall_accept_cycle", acc, acc_m + 34);
    send("multu", 3'b010, 6'b011001, 32'hFFFFFFFD, 32'h00000007,
         mdx(32'h00000006, 32'hFFFFFFEB, 33), acc);
    send("mult_nn", 3'b010, 6'b011000, 32'hFFFFFFFE, 32'hFFFFFFFD,
         mdx(32'h00000000, 32'h00000006, 33), acc);
    send("div", 3'b010, 6'b011010, 32'hFFFFFFF9, 32'h00000002,
         mdx(32'hFFFFFFFF, 32'hFFFFFFFD, 33), acc);
    send("div_pn", 3'b010, 6'b011010, 32'h00000007, 32'hFFFFFFFE,
         mdx(32'h00000001, 32'hFFFFFFFD, 33), acc);
    send("divu", 3'b010, 6'b011011, 32'd100, 32'd7,
         mdx(32'h00000002, 32'h0000000E, 33), acc);
    send("mflo", 3'b010, 6'b010010, 32'h0, 32'h0,
         ctl_hl(4'b1110, 32'h00000002, 32'h0000000E), acc);
    send("div_zero", 3'b010, 6'b011010, 32'h0000002A, 32'h00000000,
         mdx(32'h0000002A, 32'hFFFFFFFF, 1), acc);
    send("div_ovf", 3'b010, 6'b011010, 32'h80000000, 32'hFFFFFFFF,
         mdx(32'h00000000, 32'h80000000, 33), acc);
    send("mfhi", 3'b010, 6'b010000, 32'h0, 32'h0,
         ctl_hl(4'b1101, 32'h00000000, 32'h80000000), acc);
    send("mult_rst", 3'b010, 6'b011000, 32'h00000005, 32'h00000006,
         mdx(32'h00000000, 32'h0000001E, 33), acc);
    inValid = 1'b0;
    repeat (9) @(negedge Clk);
    reset = 1'b0;
    q.delete();
    #1;
    chk("arst_outValid", {63'h0, outValid}, 64'h0);
    chk("arst_aluCtrOut", {60'h0, aluCtrOut}, 64'h0);
    chk("arst_mdBusy", {63'h0, mdBusy}, 64'h0);
    chk("arst_mdDone", {63'h0, mdDone}, 64'h0);
    chk("arst_hi", {32'h0, hi}, 64'h0);
    chk("arst_lo", {32'h0, lo}, 64'h0);
    @(negedge Clk);
    reset = 1'b1;
    #1;
    chk("rel_inReady", {63'h0, inReady}, 64'h1);
    chk("rel_mdBusy", {63'h0, mdBusy}, 64'h0);
    @(negedge Clk);
    send("mfhi_post", 3'b010, 6'b010000, 32'h0, 32'h0,
         ctl_hl(4'b1101, 32'h00000000, 32'h00000000), acc);
    inValid = 1'b0;
    repeat (40) @(negedge Clk);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised successor of the single-cycle ALU control decoder. It decodes a widened aluOp plus funct into a registered aluCtrOut with a valid/ready handshake. It also owns an iterative multiply/divide sequencer with HI/LO registers, which stalls the issue side while a mult/div runs. It sits between the main control unit and the ALU/HI-LO datapath of the single-issue core.

Parameters:
DATA_W, 32, operand and HI/LO width; must be even and at least 8.
OP_W, 3, aluOp width; the 2-bit legacy encodings are zero-extended.
CTR_W, 4, aluCtrOut width.

Ports:
Clk  input  1  system clock; all state is updated on its rising edge.
reset  input  1  asynchronous, active-low reset.
inValid  input  1  request valid.
inReady  output  1  block can accept a request; equals !mdBusy.
aluOp  input  OP_W  operation class from main control.
funct  input  6  R-type function field.
opA  input  DATA_W  rs operand (used by mult/div only).
opB  input  DATA_W  rt operand (used by mult/div only).
outValid  output  1  one-cycle pulse: aluCtrOut is valid.
aluCtrOut  output  CTR_W  registered ALU control code.
mdBusy  output  1  mult/div in progress.
mdDone  output  1  one-cycle pulse: HI/LO have just been updated.
hi  output  DATA_W  HI register.
lo  output  DATA_W  LO register.

Behaviour:
- Reset (async assert, sync release). All outputs and registers clear to 0, and the FSM goes to IDLE. Reset mid-operation abandons the op; HI/LO read 0.
- Accept. A request is accepted when inValid && inReady; inputs are sampled only on accept.
- aluOp decode:
  - 000 → add 0010
  - 001 → sub 0110
  - 011 → and 0000
  - 100 → or 0001
  - 101 → slt 0111
  - 110, 111 → 1111 (illegal)
  - 010 → R-type, decoded on funct[3:0] when funct[5:4]=10: 0000 add 0010, 0010 sub 0110, 0100 and 0000, 0101 or 0001, 1010 slt 0111, 0110 xor 0011, 0111 nor 1100; any other → 1111.
- Non-mult/div accept. aluCtrOut is registered and outValid pulses exactly 1 cycle after accept. Back-to-back accepts are allowed, giving one result per cycle. aluCtrOut holds its value between pulses.
- mfhi (funct 010000) and mflo (funct 010010). outValid pulses with aluCtrOut=1101 (mfhi) or 1110 (mflo); hi/lo are already stable outputs.
- mult / multu / div / divu (funct 011000 / 011001 / 011010 / 011011 with aluOp=010). No outValid pulse. The FSM moves IDLE→RUN, and mdBusy rises the cycle after accept.
- FSM states: IDLE, RUN, FIX.
  - RUN: DATA_W iterations, one bit per cycle. Multiply is shift-add on magnitudes. Divide is restoring division on magnitudes.
  - FIX: 1 cycle. Applies signs for the signed ops: product negated if signs differ; quotient negated if signs differ; remainder takes the sign of the dividend. It then writes hi/lo and pulses mdDone before returning to IDLE.
  - mdBusy drops in the same cycle that mdDone is high, so inReady is high again that cycle.
  - Total latency from accept to mdDone is DATA_W+2 cycles.
- Results: mult writes {hi,lo} = the 2·DATA_W-bit product. div writes lo=quotient and hi=remainder.
- Divide by zero: skips RUN (IDLE→FIX). hi=opA, lo=all ones. mdDone comes 2 cycles after accept.
- Signed overflow (div of most-negative by −1): lo=most-negative value, hi=0; no trap.
- Operand capture: operands are captured at accept, so later opA/opB changes have no effect.
- While mdBusy, inReady=0. inValid is ignored and requests must be held by the source.

Decomposition:
- Shared package/header alu_ctrl_pkg:
  - aluOp encodings
  - funct codes
  - CTR_W control codes, including ILLEGAL=1111, MFHI=1101, MFLO=1110
  - FSM state encoding
- Sub-module md_iter: magnitude multiply/divide datapath with iteration counter. Interface: start, isDiv, a, b → done, hiMag, loMag. The top level handles decode, handshake, sign fix and HI/LO.

Test Plan:
- Legacy decode: aluOp=000, then 001, then 010 with funct 100000/100010/100100/100101/101010, one request per cycle → aluCtrOut 0010, 0110, 0010, 0110, 0000, 0001, 0111 on consecutive cycles, outValid high throughout.
- Illegal codes: aluOp=110 → 1111; aluOp=010 with funct=001000 → 1111.
- Signed multiply: mult opA=−3 (FFFFFFFD), opB=7 → mdBusy for 33 cycles, mdDone at accept+34, hi=FFFFFFFF, lo=FFFFFFEB. multu of the same operands → hi=00000006, lo=FFFFFFEB.
- Signed divide: div opA=−7, opB=2 → lo=FFFFFFFD, hi=FFFFFFFF. divu 100/7 → lo=0000000E, hi=00000002. Then mflo → outValid with aluCtrOut=1110 and lo unchanged.
- Divide-by-zero and overflow: div opA=0000002A, opB=0 → mdDone at accept+2, hi=0000002A, lo=FFFFFFFF. div 80000000 / FFFFFFFF → lo=80000000, hi=0.
- Stall and reset: inValid held high during a mult → no accept until mdDone. A later mult is hit by reset low at cycle 10 → all outputs are 0 immediately (async), FSM is IDLE, and inReady=1 after release.
